// File: rtl/writeback_unit.sv
// Retirement stage: accepts one instruction, waits for a load response if needed, drives two RF write ports.
// Latency: non-load and base update written one cycle after accept; load result one cycle after mem_rvalid.
// Backpressure: in_ready low and stall high while a load response is outstanding (WAIT_MEM).
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wb_en,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu,
  input  logic        in_is_load,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [1:0]  in_addr_lo,
  input  logic        in_inc_en,
  input  logic [4:0]  in_inc_reg,
  input  logic [31:0] in_inc_val,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wen0,
  output logic [4:0]  waddr0,
  output logic [31:0] wdata0,
  output logic        wen1,
  output logic [4:0]  waddr1,
  output logic [31:0] wdata1,
  output logic        stall,
  output logic [4:0]  busy_rd
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t      state_q, state_d;

  // Fields of the outstanding load, held while waiting for the response.
  logic [4:0]  rd_q,      rd_d;
  logic        wb_en_q,   wb_en_d;
  logic [1:0]  size_q,    size_d;
  logic        signed_q,  signed_d;
  logic [1:0]  addr_lo_q, addr_lo_d;

  // Registered write-port outputs.
  logic        wen0_q,   wen0_d;
  logic [4:0]  waddr0_q, waddr0_d;
  logic [31:0] wdata0_q, wdata0_d;
  logic        wen1_q,   wen1_d;
  logic [4:0]  waddr1_q, waddr1_d;
  logic [31:0] wdata1_q, wdata1_d;

  logic        accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  assign accept = in_valid && (state_q == IDLE);

  // Extract the addressed little-endian lane and extend it to 32 bits.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    half_sel = mem_rdata[15:0];
    load_fmt = mem_rdata;
    case (addr_lo_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_fmt = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Next-state, load capture and write-port scheduling.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wb_en_d   = wb_en_q;
    size_d    = size_q;
    signed_d  = signed_q;
    addr_lo_d = addr_lo_q;
    wen0_d    = 1'b0;
    waddr0_d  = waddr0_q;
    wdata0_d  = wdata0_q;
    wen1_d    = 1'b0;
    waddr1_d  = waddr1_q;
    wdata1_d  = wdata1_q;

    case (state_q)
      IDLE: begin
        // A stray mem_rvalid here has no matching load and is dropped.
        if (accept) begin
          rd_d      = in_rd;
          wb_en_d   = in_wb_en;
          size_d    = in_size;
          signed_d  = in_signed;
          addr_lo_d = in_addr_lo;
          if (in_is_load) begin
            state_d = WAIT_MEM;
          end else begin
            wen0_d   = in_wb_en && (in_rd != 5'd0);
            waddr0_d = in_rd;
            wdata0_d = in_alu;
          end
          // Base update goes out right away even for loads, so a load with
          // base == rd writes the base first and the loaded value last.
          waddr1_d = in_inc_reg;
          wdata1_d = in_inc_val;
          wen1_d   = in_inc_en && (in_inc_reg != 5'd0) &&
                     !(wen0_d && (in_rd == in_inc_reg));
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          wen0_d   = wb_en_q && (rd_q != 5'd0);
          waddr0_d = rd_q;
          wdata0_d = load_fmt;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= 5'd0;
      wb_en_q   <= 1'b0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      addr_lo_q <= 2'd0;
      wen0_q    <= 1'b0;
      waddr0_q  <= 5'd0;
      wdata0_q  <= 32'd0;
      wen1_q    <= 1'b0;
      waddr1_q  <= 5'd0;
      wdata1_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      addr_lo_q <= addr_lo_d;
      wen0_q    <= wen0_d;
      waddr0_q  <= waddr0_d;
      wdata0_q  <= wdata0_d;
      wen1_q    <= wen1_d;
      waddr1_q  <= waddr1_d;
      wdata1_q  <= wdata1_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign stall    = (state_q == WAIT_MEM);
  assign busy_rd  = (state_q == WAIT_MEM && wb_en_q) ? rd_q : 5'd0;

  assign wen0   = wen0_q;
  assign waddr0 = waddr0_q;
  assign wdata0 = wdata0_q;
  assign wen1   = wen1_q;
  assign waddr1 = waddr1_q;
  assign wdata1 = wdata1_q;

endmodule
